reorder_buffer: RTL and testbench

- Circular in-order reorder buffer for the Tomasulo core. It allocates the ROB tags that the rename map table stores and drives the map table's tag_in and load_entry signals.
- It captures CDB completions and drives the in-order retire stream: retire_entry, retire_addr and retire_tag to the map table, and a value to the register file.
- It also serves operand values to dispatch for tags the map table reports as ready-in-ROB.
- Tag 0 is reserved to mean "no tag / value in architectural regfile". Valid tags are 1..ROB_SZ.

---
 rtl/sys_defs.sv | 16 +
 rtl/rob_wrap_ptr.sv | 26 ++
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared ROB sizing, tag encoding and entry layout.
// Tag 0 is reserved as "value lives in the regfile".
package sys_defs;
  localparam int ROB_SZ = 31;
  localparam int TAG_W = 5;
  localparam int XLEN = 32;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            has_dest;
    logic [4:0]      dest;
    logic [XLEN-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_wrap_ptr.sv
// ROB pointer: counts 1..ROB_SZ and wraps back to 1.
// Tag 0 is never produced.
module rob_wrap_ptr
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [TAG_W-1:0] ptr
);

  localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(ROB_SZ);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= FIRST;
    end else if (clear) begin
      ptr <= FIRST;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? FIRST : ptr + FIRST;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags,
// captures CDB results, retires in order, serves operands.
module reorder_buffer
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic             dispatch_has_dest,
  input  logic [4:0]       dispatch_dest,
  output logic [TAG_W-1:0] dispatch_tag,
  output logic             dispatch_accept,
  output logic             dispatch_load,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [TAG_W:0]   free_count,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic [TAG_W-1:0] rs1_read_tag,
  input  logic [TAG_W-1:0] rs2_read_tag,
  output logic [XLEN-1:0]  rs1_read_value,
  output logic [XLEN-1:0]  rs2_read_value,
  output logic             rs1_read_ready,
  output logic             rs2_read_ready,
  output logic             retire_entry,
  output logic [4:0]       retire_addr,
  output logic [TAG_W-1:0] retire_tag,
  output logic [XLEN-1:0]  retire_value,
  output logic             retire_wr_en,
  input  logic             flush
);

  rob_entry_t rob [ROB_SZ+1];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0] count;
  logic cdb_hit;
  logic rs1_fwd;
  logic rs2_fwd;

  rob_wrap_ptr u_head (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (retire_entry),
    .ptr   (head)
  );

  rob_wrap_ptr u_tail (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (dispatch_accept),
    .ptr   (tail)
  );

  assign rob_empty = (count == '0);
  assign rob_full = (count == (TAG_W+1)'(ROB_SZ));
  assign free_count = (TAG_W+1)'(ROB_SZ) - count;

  assign dispatch_tag = tail;
  assign dispatch_accept = dispatch_valid && !rob_full && !flush;
  assign dispatch_load = dispatch_accept && dispatch_has_dest
                      && (dispatch_dest != 5'd0);

  assign cdb_hit = cdb_valid && (cdb_tag != NO_TAG)
                && rob[cdb_tag].valid;

  // Stale entry bits are ignored while empty.
  assign retire_entry = !rob_empty && rob[head].complete;
  assign retire_addr = rob[head].dest;
  assign retire_tag = head;
  assign retire_value = rob[head].value;
  assign retire_wr_en = retire_entry && rob[head].has_dest
                     && (rob[head].dest != 5'd0);

  assign rs1_fwd = cdb_valid && (cdb_tag == rs1_read_tag)
                && (rs1_read_tag != NO_TAG);
  assign rs2_fwd = cdb_valid && (cdb_tag == rs2_read_tag)
                && (rs2_read_tag != NO_TAG);

  assign rs1_read_ready = rs1_fwd || ((rs1_read_tag != NO_TAG)
                       && rob[rs1_read_tag].complete);
  assign rs2_read_ready = rs2_fwd || ((rs2_read_tag != NO_TAG)
                       && rob[rs2_read_tag].complete);
  assign rs1_read_value = rs1_fwd ? cdb_value
                        : (rs1_read_tag == NO_TAG) ? '0
                        : rob[rs1_read_tag].value;
  assign rs2_read_value = rs2_fwd ? cdb_value
                        : (rs2_read_tag == NO_TAG) ? '0
                        : rob[rs2_read_tag].value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (dispatch_accept && !retire_entry) begin
      count <= count + 1'b1;
    end else if (!dispatch_accept && retire_entry) begin
      count <= count - 1'b1;
    end
  end

  // Retire is applied last so a late CDB cannot revive a freed slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= ROB_SZ; i++) begin
        rob[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i <= ROB_SZ; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].complete <= 1'b0;
      end
    end else begin
      if (cdb_hit) begin
        rob[cdb_tag].complete <= 1'b1;
        rob[cdb_tag].value <= cdb_value;
      end
      if (dispatch_accept) begin
        rob[tail].valid <= 1'b1;
        rob[tail].complete <= 1'b0;
        rob[tail].has_dest <= dispatch_has_dest;
        rob[tail].dest <= dispatch_dest;
      end
      if (retire_entry) begin
        rob[head].valid <= 1'b0;
        rob[head].complete <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios plus a randomized run against a
// queue-based model of the reorder buffer.
module tb_reorder_buffer;
  import sys_defs::*;

  logic clock = 0;
  logic reset = 0;
  logic dispatch_valid = 0;
  logic dispatch_has_dest = 0;
  logic [4:0] dispatch_dest = 0;
  logic [TAG_W-1:0] dispatch_tag;
  logic dispatch_accept, dispatch_load, rob_full, rob_empty;
  logic [TAG_W:0] free_count;
  logic cdb_valid = 0;
  logic [TAG_W-1:0] cdb_tag = 0;
  logic [XLEN-1:0] cdb_value = 0;
  logic [TAG_W-1:0] rs1_read_tag = 0, rs2_read_tag = 0;
  logic [XLEN-1:0] rs1_read_value, rs2_read_value;
  logic rs1_read_ready, rs2_read_ready;
  logic retire_entry, retire_wr_en;
  logic [4:0] retire_addr;
  logic [TAG_W-1:0] retire_tag;
  logic [XLEN-1:0] retire_value;
  logic flush = 0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid),
    .dispatch_has_dest(dispatch_has_dest),
    .dispatch_dest(dispatch_dest),
    .dispatch_tag(dispatch_tag),
    .dispatch_accept(dispatch_accept),
    .dispatch_load(dispatch_load),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .free_count(free_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .rs1_read_tag(rs1_read_tag), .rs2_read_tag(rs2_read_tag),
    .rs1_read_value(rs1_read_value),
    .rs2_read_value(rs2_read_value),
    .rs1_read_ready(rs1_read_ready),
    .rs2_read_ready(rs2_read_ready),
    .retire_entry(retire_entry), .retire_addr(retire_addr),
    .retire_tag(retire_tag), .retire_value(retire_value),
    .retire_wr_en(retire_wr_en), .flush(flush)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 0;
    dispatch_has_dest = 0;
    dispatch_dest = 0;
    cdb_valid = 0;
    cdb_tag = 0;
    cdb_value = 0;
    rs1_read_tag = 0;
    rs2_read_tag = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic dispatch(input logic [4:0] d);
    dispatch_valid = 1;
    dispatch_has_dest = 1;
    dispatch_dest = d;
    tick();
    dispatch_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (dispatch_tag !== 5'd1) begin
        failures++;
        $display("FAIL reset_tag got=%0d exp=1", dispatch_tag);
      end
      checks++;
      if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_empty got=%b/%b exp=1/0",
                 rob_empty, rob_full);
      end
      checks++;
      if (free_count !== 6'd31) begin
        failures++;
        $display("FAIL reset_free got=%0d exp=31", free_count);
      end
      checks++;
      if (retire_entry !== 1'b0 || retire_wr_en !== 1'b0
          || dispatch_accept !== 1'b0 || dispatch_load !== 1'b0) begin
        failures++;
        $display("FAIL reset_outs got=%b%b%b%b exp=0000",
                 retire_entry, retire_wr_en,
                 dispatch_accept, dispatch_load);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    do_reset();
    dispatch_valid = 1;
    dispatch_has_dest = 1;
    dispatch_dest = 5;
    #1;
    checks++;
    if (dispatch_load !== 1'b1 || dispatch_tag !== 5'd1) begin
      failures++;
      $display("FAIL basic_load got=%b/%0d exp=1/1",
               dispatch_load, dispatch_tag);
    end
    tick();
    idle();
    cdb_valid = 1;
    cdb_tag = 1;
    cdb_value = 32'hDEAD;
    #1;
    checks++;
    if (retire_entry !== 1'b0) begin
      failures++;
      $display("FAIL basic_nobypass got=%b exp=0", retire_entry);
    end
    tick();
    idle();
    #1;
    checks++;
    if (retire_entry !== 1'b1 || retire_addr !== 5'd5
        || retire_tag !== 5'd1 || retire_value !== 32'hDEAD
        || retire_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL basic_retire got=%b/%0d/%0d/%h/%b exp=1/5/1/dead/1",
               retire_entry, retire_addr, retire_tag,
               retire_value, retire_wr_en);
    end
    tick();
    checks++;
    if (rob_empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty got=%b exp=1", rob_empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 31; i++) dispatch(5'(i));
    dispatch_valid = 1;
    #1;
    checks++;
    if (rob_full !== 1'b1 || free_count !== 6'd0
        || dispatch_accept !== 1'b0) begin
      failures++;
      $display("FAIL full_state got=%b/%0d/%b exp=1/0/0",
               rob_full, free_count, dispatch_accept);
    end
    dispatch_valid = 0;
    cdb_valid = 1;
    cdb_tag = 1;
    cdb_value = 32'h11;
    tick();
    idle();
    dispatch_valid = 1;
    dispatch_has_dest = 1;
    dispatch_dest = 7;
    #1;
    checks++;
    if (retire_entry !== 1'b1 || dispatch_accept !== 1'b0) begin
      failures++;
      $display("FAIL full_retire_refuse got=%b/%b exp=1/0",
               retire_entry, dispatch_accept);
    end
    tick();
    checks++;
    if (dispatch_accept !== 1'b1 || dispatch_tag !== 5'd1) begin
      failures++;
      $display("FAIL full_wrap got=%b/%0d exp=1/1",
               dispatch_accept, dispatch_tag);
    end
    tick();
    idle();
  endtask

  task automatic test_ooo();
    logic [TAG_W-1:0] order [3];
    order[0] = 3;
    order[1] = 2;
    order[2] = 1;
    do_reset();
    for (int i = 1; i <= 3; i++) dispatch(5'(i + 8));
    for (int i = 0; i < 3; i++) begin
      cdb_valid = 1;
      cdb_tag = order[i];
      cdb_value = 32'(100 + order[i]);
      #1;
      checks++;
      if (retire_entry !== 1'b0) begin
        failures++;
        $display("FAIL ooo_hold step=%0d got=%b exp=0",
                 i, retire_entry);
      end
      tick();
    end
    idle();
    for (int t = 1; t <= 3; t++) begin
      #1;
      checks++;
      if (retire_entry !== 1'b1 || retire_tag !== 5'(t)
          || retire_value !== 32'(100 + t)
          || retire_addr !== 5'(t + 8)) begin
        failures++;
        $display("FAIL ooo_order got=%b/%0d/%0d/%0d exp=1/%0d/%0d/%0d",
                 retire_entry, retire_tag, retire_value,
                 retire_addr, t, 100 + t, t + 8);
      end
      tick();
    end
  endtask

  task automatic test_forward();
    do_reset();
    dispatch(5'd1);
    dispatch(5'd2);
    rs1_read_tag = 2;
    rs2_read_tag = 0;
    cdb_valid = 1;
    cdb_tag = 2;
    cdb_value = 32'h55;
    #1;
    checks++;
    if (rs1_read_ready !== 1'b1 || rs1_read_value !== 32'h55) begin
      failures++;
      $display("FAIL fwd_rs1 got=%b/%h exp=1/55",
               rs1_read_ready, rs1_read_value);
    end
    checks++;
    if (rs2_read_ready !== 1'b0 || rs2_read_value !== 32'h0) begin
      failures++;
      $display("FAIL fwd_rs2_tag0 got=%b/%h exp=0/0",
               rs2_read_ready, rs2_read_value);
    end
    tick();
    cdb_valid = 0;
    rs2_read_tag = 1;
    #1;
    checks++;
    if (rs1_read_ready !== 1'b1 || rs1_read_value !== 32'h55
        || rs2_read_ready !== 1'b0) begin
      failures++;
      $display("FAIL fwd_stored got=%b/%h/%b exp=1/55/0",
               rs1_read_ready, rs1_read_value, rs2_read_ready);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'(i + 1));
    flush = 1;
    dispatch_valid = 1;
    #1;
    checks++;
    if (dispatch_accept !== 1'b0 || free_count !== 6'd27) begin
      failures++;
      $display("FAIL flush_cycle got=%b/%0d exp=0/27",
               dispatch_accept, free_count);
    end
    tick();
    idle();
    cdb_valid = 1;
    cdb_tag = 3;
    cdb_value = 32'h33;
    #1;
    checks++;
    if (rob_empty !== 1'b1 || dispatch_tag !== 5'd1) begin
      failures++;
      $display("FAIL flush_state got=%b/%0d exp=1/1",
               rob_empty, dispatch_tag);
    end
    tick();
    idle();
    rs1_read_tag = 3;
    #1;
    checks++;
    if (rs1_read_ready !== 1'b0 || retire_entry !== 1'b0) begin
      failures++;
      $display("FAIL flush_late_cdb got=%b/%b exp=0/0",
               rs1_read_ready, retire_entry);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dispatch(5'd4);
    dispatch(5'd6);
    cdb_valid = 1;
    cdb_tag = 1;
    cdb_value = 32'h77;
    tick();
    idle();
    #1;
    checks++;
    if (retire_entry !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%b exp=1", retire_entry);
    end
    #1;
    reset = 0;
    #1;
    checks++;
    if (retire_entry !== 1'b0 || rob_empty !== 1'b1
        || dispatch_tag !== 5'd1 || free_count !== 6'd31
        || retire_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got=%b/%b/%0d/%0d/%b exp=0/1/1/31/0",
               retire_entry, rob_empty, dispatch_tag,
               free_count, retire_wr_en);
    end
    tick();
    reset = 1;
  endtask

  task automatic test_random();
    int q[$];
    bit vld [32];
    bit cmp [32];
    bit hd [32];
    logic [4:0] dst [32];
    logic [XLEN-1:0] val [32];
    int tl;
    bit e_full, e_empty, e_acc, e_load, e_ret, e_wr, e_rdy;
    logic [XLEN-1:0] e_val;
    int h;
    do_reset();
    tl = 1;
    for (int i = 0; i < 32; i++) begin
      vld[i] = 0;
      cmp[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      dispatch_valid = ($urandom_range(0, 9) < 6);
      dispatch_has_dest = ($urandom_range(0, 3) != 0);
      dispatch_dest = 5'($urandom_range(0, 31));
      cdb_valid = $urandom_range(0, 1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_tag = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        cdb_tag = 5'($urandom_range(0, 31));
      cdb_value = $urandom;
      rs1_read_tag = ($urandom_range(0, 2) == 0) ? cdb_tag
                   : 5'($urandom_range(0, 31));
      rs2_read_tag = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 49) == 0);
      #1;
      e_full = (q.size() == ROB_SZ);
      e_empty = (q.size() == 0);
      e_acc = dispatch_valid && !e_full && !flush;
      e_load = e_acc && dispatch_has_dest && dispatch_dest != 0;
      h = e_empty ? 0 : q[0];
      e_ret = !e_empty && cmp[h];
      e_wr = e_ret && hd[h] && dst[h] != 0;
      checks++;
      if (dispatch_tag !== 5'(tl) || dispatch_accept !== e_acc
          || dispatch_load !== e_load) begin
        failures++;
        $display("FAIL rnd_dispatch c=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                 c, dispatch_tag, dispatch_accept, dispatch_load,
                 tl, e_acc, e_load);
      end
      checks++;
      if (rob_full !== e_full || rob_empty !== e_empty
          || free_count !== 6'(ROB_SZ - q.size())) begin
        failures++;
        $display("FAIL rnd_count c=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                 c, rob_full, rob_empty, free_count,
                 e_full, e_empty, ROB_SZ - q.size());
      end
      checks++;
      if (retire_entry !== e_ret || retire_wr_en !== e_wr
          || (e_ret && (retire_tag !== 5'(h)
              || retire_addr !== dst[h]
              || retire_value !== val[h]))) begin
        failures++;
        $display("FAIL rnd_retire c=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                 c, retire_entry, retire_wr_en, retire_tag,
                 e_ret, e_wr, h);
      end
      if (cdb_valid && cdb_tag == rs1_read_tag && rs1_read_tag != 0) begin
        e_rdy = 1;
        e_val = cdb_value;
      end else begin
        e_rdy = (rs1_read_tag != 0) && cmp[rs1_read_tag];
        e_val = (rs1_read_tag != 0) ? val[rs1_read_tag] : '0;
      end
      checks++;
      if (rs1_read_ready !== e_rdy
          || ((e_rdy || rs1_read_tag == 0) && rs1_read_value !== e_val)) begin
        failures++;
        $display("FAIL rnd_rs1 c=%0d tag=%0d got=%b/%h exp=%b/%h",
                 c, rs1_read_tag, rs1_read_ready, rs1_read_value,
                 e_rdy, e_val);
      end
      e_rdy = (rs2_read_tag != 0) && (cmp[rs2_read_tag]
            || (cdb_valid && cdb_tag == rs2_read_tag));
      checks++;
      if (rs2_read_ready !== e_rdy) begin
        failures++;
        $display("FAIL rnd_rs2 c=%0d tag=%0d got=%b exp=%b",
                 c, rs2_read_tag, rs2_read_ready, e_rdy);
      end
      if (flush) begin
        q.delete();
        for (int i = 0; i < 32; i++) begin
          vld[i] = 0;
          cmp[i] = 0;
        end
        tl = 1;
      end else begin
        if (cdb_valid && cdb_tag != 0 && vld[cdb_tag]) begin
          cmp[cdb_tag] = 1;
          val[cdb_tag] = cdb_value;
        end
        if (e_ret) begin
          void'(q.pop_front());
          vld[h] = 0;
          cmp[h] = 0;
        end
        if (e_acc) begin
          vld[tl] = 1;
          cmp[tl] = 0;
          hd[tl] = dispatch_has_dest;
          dst[tl] = dispatch_dest;
          q.push_back(tl);
          tl = (tl % ROB_SZ) + 1;
        end
      end
      @(posedge clock);
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_ooo();
    test_forward();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
